// File: rtl/gpr_file.sv
// Parametrised general-purpose register file: NRP combinational read ports, one write port,
// sequential clear engine after reset, hard-wired zero register. `GPR_BYPASS_EN adds write-to-read bypass.
module gpr_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_busy,
  input  logic                gpr_we,
  input  logic [AW-1:0]       gpr_rd,
  input  logic                wsel,
  input  logic [XLEN-1:0]     gpr_di,
  input  logic [XLEN-1:0]     csr_rdata,
  input  logic [NRP*AW-1:0]   gpr_ra,
  output logic [NRP*XLEN-1:0] q
);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] mem [NREG];
  logic            wr_en;
  logic [XLEN-1:0] wdata;

  assign wr_en = (state == RUN) && gpr_we && (gpr_rd != '0);
  assign wdata = wsel ? csr_rdata : gpr_di;

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      clr_idx   <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(NREG - 1)) begin
            state     <= RUN;
            init_busy <= 1'b0;
          end
        end
        default: init_busy <= 1'b0;
      endcase
    end
  end

  // NOTE: the array has no reset branch so it maps onto plain RAM; the clear engine zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[clr_idx] <= '0;
      end else if (wr_en) begin
        mem[gpr_rd] <= wdata;
      end
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rport
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd_data;

    assign ra = gpr_ra[p*AW +: AW];

    // NOTE: rd_data gets a default on entry so no path through the block can infer a latch.
    always_comb begin
      rd_data = mem[ra];
`ifdef GPR_BYPASS_EN
      if (wr_en && (ra == gpr_rd)) begin
        rd_data = wdata;
      end
`endif
      // Zero register and the clear window win over stored or bypassed data.
      if (init_busy || (ra == '0)) begin
        rd_data = '0;
      end
    end

    assign q[p*XLEN +: XLEN] = rd_data;
  end

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file (default 32x32, two read ports); expectations follow GPR_BYPASS_EN when defined.
module tb_gpr_file;

`ifdef GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        init_busy;
  logic        gpr_we;
  logic [4:0]  gpr_rd;
  logic        wsel;
  logic [31:0] gpr_di;
  logic [31:0] csr_rdata;
  logic [4:0]  ra0, ra1;
  logic [63:0] q;

  gpr_file #(.XLEN(32), .NREG(32), .AW(5), .NRP(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .gpr_we    (gpr_we),
    .gpr_rd    (gpr_rd),
    .wsel      (wsel),
    .gpr_di    (gpr_di),
    .csr_rdata (csr_rdata),
    .gpr_ra    ({ra1, ra0}),
    .q         (q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic        wsel;
    logic [31:0] di;
    logic [31:0] csr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[12];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all(input string tag);
    for (int r = 0; r < 32; r++) begin
      ra0 = 5'(r);
      ra1 = 5'(31 - r);
      #1;
      check($sformatf("%s x%0d p0", tag, r), 64'(q[31:0]), 64'h0);
      check($sformatf("%s x%0d p1", tag, 31 - r), 64'(q[63:32]), 64'h0);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; gpr_we = 1'b0; gpr_rd = '0; wsel = 1'b0;
    gpr_di = '0; csr_rdata = '0; ra0 = '0; ra1 = '0;

    //           we    rd     wsel  di             csr            ra0    ra1    e0                                 e1
    vecs[0]  = '{1'b1, 5'd5,  1'b0, 32'hDEADBEEF, 32'h0,         5'd5,  5'd0,  BYP ? 32'hDEADBEEF : 32'h0,       32'h0};
    vecs[1]  = '{1'b1, 5'd7,  1'b1, 32'h00000BAD, 32'h12345678,  5'd5,  5'd7,  32'hDEADBEEF,                     BYP ? 32'h12345678 : 32'h0};
    vecs[2]  = '{1'b0, 5'd7,  1'b0, 32'h0,         32'h0,         5'd7,  5'd5,  32'h12345678,                     32'hDEADBEEF};
    vecs[3]  = '{1'b1, 5'd0,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,  5'd0,  5'd0,  32'h0,                            32'h0};
    vecs[4]  = '{1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         5'd0,  5'd0,  32'h0,                            32'h0};
    vecs[5]  = '{1'b1, 5'd3,  1'b0, 32'h00000011, 32'h0,         5'd5,  5'd3,  32'hDEADBEEF,                     BYP ? 32'h11 : 32'h0};
    vecs[6]  = '{1'b1, 5'd3,  1'b0, 32'h00000022, 32'h0,         5'd3,  5'd3,  BYP ? 32'h22 : 32'h11,            BYP ? 32'h22 : 32'h11};
    vecs[7]  = '{1'b0, 5'd3,  1'b0, 32'h0,         32'h0,         5'd3,  5'd7,  32'h22,                           32'h12345678};
    vecs[8]  = '{1'b1, 5'd31, 1'b1, 32'h0,         32'hA5A5A5A5,  5'd31, 5'd30, BYP ? 32'hA5A5A5A5 : 32'h0,       32'h0};
    vecs[9]  = '{1'b0, 5'd30, 1'b1, 32'h0,         32'hFFFFFFFF,  5'd31, 5'd30, 32'hA5A5A5A5,                     32'h0};
    vecs[10] = '{1'b1, 5'd5,  1'b0, 32'hCAFEF00D, 32'h00000999,  5'd5,  5'd5,  BYP ? 32'hCAFEF00D : 32'hDEADBEEF, BYP ? 32'hCAFEF00D : 32'hDEADBEEF};
    vecs[11] = '{1'b0, 5'd5,  1'b0, 32'h0,         32'h0,         5'd5,  5'd0,  32'hCAFEF00D,                     32'h0};

    // Reset held 3 cycles, then count the clear window; a write in the 2nd init cycle must be dropped.
    repeat (3) tick();
    check("busy in reset", 64'(init_busy), 64'h1);
    check("q in reset", q, 64'h0);
    rst = 1'b0;
    cnt = 0;
    while (init_busy && cnt < 100) begin
      if (cnt == 1) begin
        gpr_we = 1'b1; gpr_rd = 5'd9; gpr_di = 32'hAA; ra0 = 5'd9;
      end else begin
        gpr_we = 1'b0;
      end
      tick();
      cnt++;
    end
    gpr_we = 1'b0;
    check("init length", 64'(cnt), 64'd32);
    check("busy after init", 64'(init_busy), 64'h0);
    ra0 = 5'd9; ra1 = 5'd9;
    #1;
    check("x9 after init write", q, 64'h0);
    read_all("post-reset");

    // Table-driven write/read vectors; q is checked before the edge that performs the write.
    for (int i = 0; i < 12; i++) begin
      gpr_we = vecs[i].we; gpr_rd = vecs[i].rd; wsel = vecs[i].wsel;
      gpr_di = vecs[i].di; csr_rdata = vecs[i].csr;
      ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
      #2;
      check($sformatf("vec%0d q0", i), 64'(q[31:0]), 64'(vecs[i].e0));
      check($sformatf("vec%0d q1", i), 64'(q[63:32]), 64'(vecs[i].e1));
      check($sformatf("vec%0d busy", i), 64'(init_busy), 64'h0);
      tick();
    end
    gpr_we = 1'b0;

    // Reset from RUN, then a one-cycle reset at init cycle 10 restarts the full clear.
    ra0 = 5'd5; ra1 = 5'd31;
    rst = 1'b1;
    tick();
    check("busy after run reset", 64'(init_busy), 64'h1);
    check("q forced during init", q, 64'h0);
    rst = 1'b0;
    cnt = 0;
    while (init_busy && cnt < 10) begin
      tick();
      cnt++;
    end
    check("busy at init cycle 10", 64'(init_busy), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("busy after mid-init reset", 64'(init_busy), 64'h1);
    cnt = 0;
    while (init_busy && cnt < 100) begin
      tick();
      cnt++;
    end
    check("restarted init length", 64'(cnt), 64'd32);
    read_all("post-mid-init");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
